// File: rtl/particle_bin_receiver_pkg.sv
// Shared types and defaults for the particle bin receiver: FSM encoding,
// particle record layout and default sizing.
package particle_bin_receiver_pkg;

  localparam int DEF_DATA_WIDTH              = 160;
  localparam int DEF_ADDR_WIDTH              = 7;
  localparam int DEF_BIN_DEPTH               = 128;
  localparam int DEF_NUM_NEIGHBOR_BIN        = 6;
  localparam int DEF_NEIGHBOR_BIN_ADDR_WIDTH = 3;

  localparam int LINK_FIFO_DEPTH = 2;
  localparam int FIELD_WIDTH     = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECEIVE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } rx_state_e;

  // Record layout, LSB first: pos_x [31:0], pos_y [63:32], pos_z [95:64],
  // vel [127:96], id [159:128].
  typedef struct packed {
    logic [FIELD_WIDTH-1:0] id;
    logic [FIELD_WIDTH-1:0] vel;
    logic [FIELD_WIDTH-1:0] pos_z;
    logic [FIELD_WIDTH-1:0] pos_y;
    logic [FIELD_WIDTH-1:0] pos_x;
  } particle_t;

endpackage

// File: rtl/particle_bin_receiver_link_fifo.sv
// particle_link_fifo: 2-entry FIFO buffering one neighbour link.
// A push into a full FIFO is dropped unless a pop frees the slot that cycle.
module particle_link_fifo #(
  parameter int WIDTH = 160
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = i_pop && (r_count != 2'd0);
  assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + 2'(w_do_push) - 2'(w_do_pop);
    end
  end

  // NOTE: storage is not reset; r_count alone says which entries are valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign o_count = r_count;

endmodule

// File: rtl/particle_bin_receiver.sv
// particle_bin_receiver: buffers migrating particles per neighbour link and
// appends them round-robin to the local bin. Define PARTICLE_BIN_RECEIVER_STATS_EN for rx_stats.
module particle_bin_receiver
  import particle_bin_receiver_pkg::*;
#(
  parameter int DATA_WIDTH              = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH              = DEF_ADDR_WIDTH,
  parameter int BIN_DEPTH               = DEF_BIN_DEPTH,
  parameter int NUM_NEIGHBOR_BIN        = DEF_NUM_NEIGHBOR_BIN,
  parameter int NEIGHBOR_BIN_ADDR_WIDTH = DEF_NEIGHBOR_BIN_ADDR_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   motion_update_enable,
  input  logic [ADDR_WIDTH:0]                    local_particle_count,
  input  logic [NUM_NEIGHBOR_BIN-1:0]            global_incom_particle_data_valid,
  input  logic [NUM_NEIGHBOR_BIN*DATA_WIDTH-1:0] global_incom_particle_data_in,
  output logic                                   particle_input_available_to_neighbors,
  output logic                                   bin_wr_en,
  output logic [ADDR_WIDTH-1:0]                  bin_wr_addr,
  output logic [DATA_WIDTH-1:0]                  bin_wr_data,
  output logic [ADDR_WIDTH:0]                    particle_count,
  output logic                                   receive_done,
  output logic                                   overflow
`ifdef PARTICLE_BIN_RECEIVER_STATS_EN
  ,
  output logic [NUM_NEIGHBOR_BIN*8-1:0]          rx_stats
`endif
);

  localparam int               CW     = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]    L_FULL = CW'(BIN_DEPTH);

  rx_state_e                           r_state;
  logic                                r_en_d;
  logic                                r_ready;
  logic                                r_bin_wr_en;
  logic [ADDR_WIDTH-1:0]               r_bin_wr_addr;
  logic [DATA_WIDTH-1:0]               r_bin_wr_data;
  logic [CW-1:0]                       r_count;
  logic                                r_done;
  logic                                r_overflow;
  logic [NEIGHBOR_BIN_ADDR_WIDTH-1:0]  r_ptr;

  logic [NUM_NEIGHBOR_BIN-1:0]         w_push_req, w_push_ok, w_drop, w_pop;
  logic [NUM_NEIGHBOR_BIN-1:0]         w_full, w_empty, w_empty_next;
  logic [DATA_WIDTH-1:0]               w_head   [NUM_NEIGHBOR_BIN];
  logic [1:0]                          w_fcount [NUM_NEIGHBOR_BIN];
  logic                                w_accept, w_start, w_grant, w_write, w_ready_next;
  logic [NEIGHBOR_BIN_ADDR_WIDTH-1:0]  w_grant_idx;
  logic [CW-1:0]                       w_count_next;

  assign w_accept   = (r_state == ST_RECEIVE) || (r_state == ST_DRAIN);
  assign w_start    = (r_state == ST_IDLE) && motion_update_enable && !r_en_d;
  assign w_push_req = w_accept ? global_incom_particle_data_valid : '0;
  assign w_drop     = w_push_req & w_full & ~w_pop;
  assign w_push_ok  = w_push_req & ~w_drop;

  for (genvar i = 0; i < NUM_NEIGHBOR_BIN; i++) begin : g_link
    particle_link_fifo #(.WIDTH(DATA_WIDTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push_req[i]),
      .i_pop   (w_pop[i]),
      .i_data  (global_incom_particle_data_in[i*DATA_WIDTH +: DATA_WIDTH]),
      .o_head  (w_head[i]),
      .o_full  (w_full[i]),
      .o_empty (w_empty[i]),
      .o_count (w_fcount[i])
    );
    assign w_empty_next[i] = ~w_push_ok[i] & (w_empty[i] | ((w_fcount[i] == 2'd1) & w_pop[i]));
  end

  // Round-robin: first non-empty link strictly after the last grant.
  always_comb begin
    // NOTE: defaults first so every path assigns each output; no latch inferred.
    w_grant     = 1'b0;
    w_grant_idx = r_ptr;
    w_pop       = '0;
    for (int k = 1; k <= NUM_NEIGHBOR_BIN; k++) begin
      if (!w_grant && !w_empty[(int'(r_ptr) + k) % NUM_NEIGHBOR_BIN]) begin
        w_grant     = 1'b1;
        w_grant_idx = NEIGHBOR_BIN_ADDR_WIDTH'((int'(r_ptr) + k) % NUM_NEIGHBOR_BIN);
      end
    end
    if (w_grant) w_pop[w_grant_idx] = 1'b1;
  end

  assign w_write      = w_grant && (r_count != L_FULL);
  assign w_count_next = r_count + CW'(w_write);
  // Every link may still land one particle per FIFO slot after ready drops.
  assign w_ready_next = (r_state == ST_RECEIVE) && motion_update_enable && (&w_empty_next)
                        && ((int'(w_count_next) + NUM_NEIGHBOR_BIN * LINK_FIFO_DEPTH) <= BIN_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_en_d        <= 1'b0;
      r_ready       <= 1'b0;
      r_bin_wr_en   <= 1'b0;
      r_bin_wr_addr <= '0;
      r_bin_wr_data <= '0;
      r_count       <= '0;
      r_done        <= 1'b0;
      r_overflow    <= 1'b0;
      r_ptr         <= '0;
    end else begin
      r_en_d      <= motion_update_enable;
      r_ready     <= w_ready_next;
      r_bin_wr_en <= w_write;
      r_count     <= w_count_next;
      r_done      <= 1'b0;
      if (w_write) begin
        r_bin_wr_addr <= r_count[ADDR_WIDTH-1:0];
        r_bin_wr_data <= w_head[w_grant_idx];
      end
      if (w_grant) r_ptr <= w_grant_idx;
      if ((w_grant && !w_write) || (|w_drop)) r_overflow <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_RECEIVE;
            r_ptr   <= '0;
            if (int'(local_particle_count) > BIN_DEPTH) begin
              r_count    <= L_FULL;
              r_overflow <= 1'b1;
            end else begin
              r_count    <= local_particle_count;
              r_overflow <= 1'b0;
            end
          end
        end
        ST_RECEIVE: if (!motion_update_enable) r_state <= ST_DRAIN;
        ST_DRAIN: begin
          if ((&w_empty) && !(|w_push_req) && !r_bin_wr_en) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef PARTICLE_BIN_RECEIVER_STATS_EN
  logic [7:0] r_stats [NUM_NEIGHBOR_BIN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEIGHBOR_BIN; i++) r_stats[i] <= 8'd0;
    end else begin
      for (int i = 0; i < NUM_NEIGHBOR_BIN; i++) begin
        if (w_start)                                  r_stats[i] <= 8'd0;
        else if (w_push_ok[i] && r_stats[i] != 8'hFF) r_stats[i] <= r_stats[i] + 8'd1;
      end
    end
  end

  for (genvar i = 0; i < NUM_NEIGHBOR_BIN; i++) begin : g_stats
    assign rx_stats[i*8 +: 8] = r_stats[i];
  end
`endif

  assign particle_input_available_to_neighbors = r_ready;
  assign bin_wr_en      = r_bin_wr_en;
  assign bin_wr_addr    = r_bin_wr_addr;
  assign bin_wr_data    = r_bin_wr_data;
  assign particle_count = r_count;
  assign receive_done   = r_done;
  assign overflow       = r_overflow;

endmodule
